wb_result_pipe: RTL and testbench

- Variable-latency result pipeline between the execute stage and the register-file write port.
- Each accepted instruction's 128-bit result is held for its unit latency, then presented on a single write-back port.
- Reports pending-write (RAW busy) status for the three decode read addresses.
- Rejects issues that would collide on the write port or break write-after-write order.

---
 rtl/spu_pkg.sv | 15 +
 rtl/wb_reg_match.sv | 28 ++
 rtl/wb_result_pipe.sv | 122 ++++++++++++
 tb/tb_wb_result_pipe.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/spu_pkg.sv
// rtl/spu_pkg.sv - shared widths, default depth and slot entry type for the result pipe
package spu_pkg;

    localparam int DATA_W     = 128;
    localparam int REG_ADDR_W = 7;
    localparam int WB_DEPTH   = 7;
    localparam int LAT_W      = 3;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rt;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/wb_reg_match.sv
// rtl/wb_reg_match.sv - per-query priority matcher over the pipeline slots (hit, busy, youngest data)
module wb_reg_match
    import spu_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter bit FWD_EN = 1'b0
)(
    input  wb_entry_t             slots [DEPTH],
    input  logic [REG_ADDR_W-1:0] query,
    output logic                  hit,
    output logic                  busy,
    output logic [DATA_W-1:0]     data
);

    // Scan oldest to youngest so the highest-index match (youngest write) wins the data.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (slots[k].valid && slots[k].rt == query) begin
                hit  = 1'b1;
                data = slots[k].data;
            end
        end
        busy = hit && !FWD_EN;
    end

endmodule

// File: rtl/wb_result_pipe.sv
// rtl/wb_result_pipe.sv - variable-latency write-back pipe with RAW busy; WB_FWD_EN adds forwarding ports
module wb_result_pipe
    import spu_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rt,
    input  logic [LAT_W-1:0]      issue_latency,
    input  logic [DATA_W-1:0]     issue_result,
    output logic                  issue_ready,
    input  logic [REG_ADDR_W-1:0] query_ra,
    input  logic [REG_ADDR_W-1:0] query_rb,
    input  logic [REG_ADDR_W-1:0] query_rc,
    output logic                  busy_ra,
    output logic                  busy_rb,
    output logic                  busy_rc,
`ifdef WB_FWD_EN
    output logic                  fwd_hit_ra,
    output logic                  fwd_hit_rb,
    output logic                  fwd_hit_rc,
    output logic [DATA_W-1:0]     fwd_data_ra,
    output logic [DATA_W-1:0]     fwd_data_rb,
    output logic [DATA_W-1:0]     fwd_data_rc,
`endif
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_rt,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  collision_err
);

`ifdef WB_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    wb_entry_t             stage [DEPTH];
    logic                  lat_ok;
    logic                  slot_free;
    logic                  waw_ok;
    logic [LAT_W-1:0]      lat_idx;
    logic [REG_ADDR_W-1:0] m_query [3];
    logic [2:0]            m_hit;
    logic [2:0]            m_busy;
    logic [DATA_W-1:0]     m_data [3];

    assign lat_idx = issue_latency - LAT_W'(1);

    // Accept only if the target retire slot is free and no same-rt write retires at or after it.
    always_comb begin
        lat_ok    = (issue_latency != '0) && (int'(issue_latency) <= DEPTH);
        slot_free = 1'b1;
        waw_ok    = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            if (k == int'(issue_latency) && stage[k].valid)
                slot_free = 1'b0;
            if (k >= int'(issue_latency) && stage[k].valid && stage[k].rt == issue_rt)
                waw_ok = 1'b0;
        end
        issue_ready = lat_ok && slot_free && waw_ok;
    end

    // Shift toward the write port each edge; an accepted offer lands in its post-shift slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++)
                stage[k] <= '0;
        end else begin
            for (int k = 0; k < DEPTH - 1; k++)
                stage[k] <= stage[k+1];
            stage[DEPTH-1] <= '0;
            if (issue_valid && issue_ready)
                stage[lat_idx] <= '{valid: 1'b1, rt: issue_rt, data: issue_result};
        end
    end

    // Sticky record that some offer was dropped since reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            collision_err <= 1'b0;
        else if (issue_valid && !issue_ready)
            collision_err <= 1'b1;
    end

    assign wb_valid = stage[0].valid;
    assign wb_rt    = stage[0].rt;
    assign wb_data  = stage[0].data;

    assign m_query[0] = query_ra;
    assign m_query[1] = query_rb;
    assign m_query[2] = query_rc;

    for (genvar q = 0; q < 3; q++) begin : g_match
        wb_reg_match #(.DEPTH(DEPTH), .FWD_EN(FWD_EN)) u_match (
            .slots (stage),
            .query (m_query[q]),
            .hit   (m_hit[q]),
            .busy  (m_busy[q]),
            .data  (m_data[q])
        );
    end

    assign busy_ra = m_busy[0];
    assign busy_rb = m_busy[1];
    assign busy_rc = m_busy[2];

`ifdef WB_FWD_EN
    assign fwd_hit_ra  = m_hit[0];
    assign fwd_hit_rb  = m_hit[1];
    assign fwd_hit_rc  = m_hit[2];
    assign fwd_data_ra = m_data[0];
    assign fwd_data_rb = m_data[1];
    assign fwd_data_rc = m_data[2];
`else
    logic unused_match;
    assign unused_match = ^{m_hit, m_data[0], m_data[1], m_data[2]};
`endif

endmodule

// File: tb/tb_wb_result_pipe.sv
// tb/tb_wb_result_pipe.sv - randomized scoreboard bench for wb_result_pipe
module tb_wb_result_pipe;

    localparam int DEPTH = 7;
    localparam int DW    = 128;
    localparam int AW    = 7;
`ifdef WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          issue_valid = 1'b0;
    logic [AW-1:0] issue_rt = '0;
    logic [2:0]    issue_latency = '0;
    logic [DW-1:0] issue_result = '0;
    logic          issue_ready;
    logic [AW-1:0] query_ra = '0, query_rb = '0, query_rc = '0;
    logic          busy_ra, busy_rb, busy_rc;
`ifdef WB_FWD_EN
    logic          fwd_hit_ra, fwd_hit_rb, fwd_hit_rc;
    logic [DW-1:0] fwd_data_ra, fwd_data_rb, fwd_data_rc;
`endif
    logic          wb_valid;
    logic [AW-1:0] wb_rt;
    logic [DW-1:0] wb_data;
    logic          collision_err;

    wb_result_pipe dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_rt(issue_rt), .issue_latency(issue_latency),
        .issue_result(issue_result), .issue_ready(issue_ready),
        .query_ra(query_ra), .query_rb(query_rb), .query_rc(query_rc),
        .busy_ra(busy_ra), .busy_rb(busy_rb), .busy_rc(busy_rc),
`ifdef WB_FWD_EN
        .fwd_hit_ra(fwd_hit_ra), .fwd_hit_rb(fwd_hit_rb), .fwd_hit_rc(fwd_hit_rc),
        .fwd_data_ra(fwd_data_ra), .fwd_data_rb(fwd_data_rb), .fwd_data_rc(fwd_data_rc),
`endif
        .wb_valid(wb_valid), .wb_rt(wb_rt), .wb_data(wb_data),
        .collision_err(collision_err)
    );

    always #5 clk = ~clk;

    // Pending writes in terms of the absolute cycle in which each one retires.
    typedef struct {
        logic [AW-1:0] rt;
        logic [DW-1:0] data;
        int            retire;
    } pw_t;

    pw_t pend[$];
    pw_t sb_q[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    bit  exp_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit model_ready(input logic [AW-1:0] rt, input int lat);
        int t;
        t = cyc + lat;
        if (lat < 1 || lat > DEPTH) return 1'b0;
        foreach (pend[i]) begin
            if (pend[i].retire == t) return 1'b0;
            if (pend[i].rt == rt && pend[i].retire >= t) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit model_hit(input logic [AW-1:0] q);
        foreach (pend[i]) if (pend[i].rt == q) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [DW-1:0] model_young(input logic [AW-1:0] q);
        int best;
        logic [DW-1:0] d;
        best = -1;
        d = '0;
        foreach (pend[i])
            if (pend[i].rt == q && pend[i].retire > best) begin
                best = pend[i].retire;
                d = pend[i].data;
            end
        return d;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One stimulus cycle: drive, check combinational outputs against the model, record outcome.
    task automatic step(input bit v, input logic [AW-1:0] rt, input int lat, input logic [DW-1:0] d,
                        input logic [AW-1:0] qa, input logic [AW-1:0] qb, input logic [AW-1:0] qc);
        bit rdy;
        @(negedge clk);
        for (int i = pend.size() - 1; i >= 0; i--)
            if (pend[i].retire < cyc) pend.delete(i);
        issue_valid   = v;
        issue_rt      = rt;
        issue_latency = 3'(lat);
        issue_result  = d;
        query_ra = qa; query_rb = qb; query_rc = qc;
        #1;
        rdy = model_ready(rt, lat);
        chk("issue_ready", {127'b0, issue_ready}, {127'b0, rdy});
        chk("busy_ra", {127'b0, busy_ra}, {127'b0, model_hit(qa) && !FWD});
        chk("busy_rb", {127'b0, busy_rb}, {127'b0, model_hit(qb) && !FWD});
        chk("busy_rc", {127'b0, busy_rc}, {127'b0, model_hit(qc) && !FWD});
        chk("collision_err", {127'b0, collision_err}, {127'b0, exp_err});
`ifdef WB_FWD_EN
        chk("fwd_hit_ra", {127'b0, fwd_hit_ra}, {127'b0, model_hit(qa)});
        chk("fwd_data_ra", fwd_data_ra, model_young(qa));
`endif
        if (v) begin
            if (rdy) begin
                pend.push_back('{rt: rt, data: d, retire: cyc + lat});
                sb_q.push_back('{rt: rt, data: d, retire: cyc + lat});
            end else begin
                exp_err = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1, '0, 7'd5, 7'd9, 7'd3);
    endtask

    task automatic apply_reset(input logic [AW-1:0] qa, input logic [AW-1:0] qb, input logic [AW-1:0] qc);
        @(negedge clk);
        issue_valid = 1'b0;
        query_ra = qa; query_rb = qb; query_rc = qc;
        reset = 1'b0;
        #1;
        chk("rst wb_valid", {127'b0, wb_valid}, '0);
        chk("rst wb_rt", {121'b0, wb_rt}, '0);
        chk("rst wb_data", wb_data, '0);
        chk("rst busy", {125'b0, busy_ra, busy_rb, busy_rc}, '0);
        chk("rst collision_err", {127'b0, collision_err}, '0);
        pend.delete();
        sb_q.delete();
        exp_err = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Monitor: every write-back must match a scoreboard entry due this exact cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                if (wb_valid) begin
                    int idx;
                    idx = -1;
                    foreach (sb_q[i]) if (sb_q[i].retire == cyc) idx = i;
                    checks++;
                    if (idx < 0) begin
                        errors++;
                        $display("FAIL wb_unexpected cycle %0d: got rt %0d data %0h expected no write-back", cyc, wb_rt, wb_data);
                    end else begin
                        chk("wb_rt", {121'b0, wb_rt}, {121'b0, sb_q[idx].rt});
                        chk("wb_data", wb_data, sb_q[idx].data);
                        sb_q.delete(idx);
                    end
                end
                for (int i = sb_q.size() - 1; i >= 0; i--) begin
                    if (sb_q[i].retire <= cyc) begin
                        checks++;
                        errors++;
                        $display("FAIL wb_missing cycle %0d: got wb_valid %0b expected rt %0d due cycle %0d", cyc, wb_valid, sb_q[i].rt, sb_q[i].retire);
                        sb_q.delete(i);
                    end
                end
            end
        end
    end

    initial begin
        // Reset state while held.
        repeat (2) @(negedge clk);
        #1;
        chk("init wb_valid", {127'b0, wb_valid}, '0);
        chk("init wb_data", wb_data, '0);
        chk("init collision_err", {127'b0, collision_err}, '0);
        @(negedge clk);
        reset = 1'b1;

        // Basic latency-2 write with busy window.
        step(1'b1, 7'd5, 2, 128'hA, 7'd5, 7'd5, 7'd5);
        idle(8);
        // Slot collision: L=4 then L=3.
        step(1'b1, 7'd10, 4, 128'h44, 7'd10, 7'd11, 7'd0);
        step(1'b1, 7'd11, 3, 128'h33, 7'd10, 7'd11, 7'd0);
        idle(8);
        // WAW: same rt shorter is rejected, longer is accepted.
        step(1'b1, 7'd9, 6, 128'h66, 7'd9, 7'd0, 7'd0);
        step(1'b1, 7'd9, 2, 128'h22, 7'd9, 7'd0, 7'd0);
        step(1'b1, 7'd9, 7, 128'h77, 7'd9, 7'd0, 7'd0);
        idle(10);
        // Illegal latencies (8 wraps to 0 on the 3-bit port).
        step(1'b1, 7'd1, 0, 128'h1, 7'd1, 7'd0, 7'd0);
        step(1'b1, 7'd1, 8, 128'h2, 7'd1, 7'd0, 7'd0);
        idle(3);
        // Forwarding-style query one cycle after issue.
        step(1'b1, 7'd3, 6, 128'h55, 7'd0, 7'd0, 7'd0);
        step(1'b0, 7'd0, 1, '0, 7'd3, 7'd0, 7'd0);
        idle(8);
        // Reset mid-flight with three results pending.
        step(1'b1, 7'd20, 5, rand_data(), 7'd20, 7'd21, 7'd22);
        step(1'b1, 7'd21, 5, rand_data(), 7'd20, 7'd21, 7'd22);
        step(1'b1, 7'd22, 5, rand_data(), 7'd20, 7'd21, 7'd22);
        apply_reset(7'd20, 7'd21, 7'd22);
        idle(9);
        // Randomized traffic over a small register range to provoke collisions.
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 9) < 7, 7'($urandom_range(0, 7)), $urandom_range(0, 7), rand_data(),
                 7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)));
        end
        idle(10);
        chk("scoreboard drained", {96'b0, 32'(sb_q.size())}, '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
